// File: rtl/multi_channel_envelope_generator_pkg.sv
// Shared constants, FSM encoding and seed/LFSR helpers for the
// multi-channel Ornstein-Uhlenbeck envelope generator.
package env_pkg;

  localparam int ONE    = 16384;
  localparam int HALF   = 8192;
  localparam int ONE_P5 = 24576;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] SEED_MIX      = 16'h9E37;
  localparam logic [15:0] SEED_ZERO_SUB = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_e;

  // An all-zero seed would lock the LFSR, so it is swapped for a fixed one.
  function automatic logic [15:0] mix_seed(input logic [15:0] base, input int unsigned k);
    logic [15:0] s;
    s = base ^ 16'(k * SEED_MIX);
    return (s == 16'h0000) ? SEED_ZERO_SUB : s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

endpackage

// File: rtl/multi_channel_envelope_generator_ou_step.sv
// Combinational single-channel OU update: LFSR advance, mean-reverting
// drift, scaled noise, then clamp to [env_min, env_max] with env_min winning.
module ou_step
  import env_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int MEAN        = ONE,
  parameter int DRIFT_SHIFT = 8,
  parameter int NOISE_SHIFT = 15
) (
  input  logic signed [WIDTH-1:0] env_i,
  input  logic        [15:0]      lfsr_i,
  input  logic signed [WIDTH-1:0] tau_inv_i,
  input  logic signed [WIDTH-1:0] sigma_i,
  input  logic signed [WIDTH-1:0] env_min_i,
  input  logic signed [WIDTH-1:0] env_max_i,
  output logic signed [WIDTH-1:0] env_o,
  output logic        [15:0]      lfsr_o
);

  localparam int IW = 2 * WIDTH + 2;

  logic signed [IW-1:0] env_x;
  logic signed [IW-1:0] n_x;
  logic signed [IW-1:0] drift;
  logic signed [IW-1:0] noise;
  logic signed [IW-1:0] sum;
  logic signed [IW-1:0] clamped;

  always_comb begin
    lfsr_o  = lfsr_next(lfsr_i);
    env_x   = IW'(env_i);
    n_x     = IW'($signed(lfsr_o));
    drift   = ((IW'(MEAN) - env_x) * IW'(tau_inv_i)) >>> DRIFT_SHIFT;
    noise   = (n_x * IW'(sigma_i)) >>> NOISE_SHIFT;
    sum     = env_x + drift + noise;
    // NOTE: blocking reassignment is deliberate here; the max clamp must be
    // visible to the min clamp so that env_min wins when min > max.
    clamped = (sum > IW'(env_max_i)) ? IW'(env_max_i) : sum;
    clamped = (clamped < IW'(env_min_i)) ? IW'(env_min_i) : clamped;
    env_o   = WIDTH'(clamped);
  end

endmodule

// File: rtl/multi_channel_envelope_generator.sv
// Time-multiplexed bank of NCH OU envelopes sharing one ou_step datapath;
// the sweep FSM walks one channel per cycle and publishes all channels at once.
module multi_channel_envelope_generator
  import env_pkg::*;
#(
  parameter int          WIDTH        = 18,
  parameter int          FRAC         = 14,
  parameter int          NCH          = 4,
  parameter int          MEAN         = ONE,
  parameter int          DRIFT_SHIFT  = 8,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    seed_load,
  input  logic        [15:0]      seed_base,
  input  logic signed [WIDTH-1:0] tau_inv,
  input  logic signed [WIDTH-1:0] sigma,
  input  logic signed [WIDTH-1:0] env_min,
  input  logic signed [WIDTH-1:0] env_max,
  input  logic                    freeze,
  output logic [NCH*WIDTH-1:0]    envelope,
  output logic                    env_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int                   CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]        LAST_CH  = CW'(NCH - 1);
  localparam logic [NCH*WIDTH-1:0] MEAN_VEC = {NCH{WIDTH'(MEAN)}};

  state_e                  state_q;
  logic [CW-1:0]           ch_q;
  logic                    frz_q;
  logic signed [WIDTH-1:0] env_q  [NCH];
  logic        [15:0]      lfsr_q [NCH];
  logic [NCH*WIDTH-1:0]    envelope_q;
  logic [NCH*WIDTH-1:0]    envelope_d;
  logic                    env_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  logic signed [WIDTH-1:0] step_env;
  logic        [15:0]      step_lfsr;

  // Noise term: Q15 LFSR sample times Q(FRAC) gain, rescaled back to Q(FRAC).
  ou_step #(
    .WIDTH       (WIDTH),
    .MEAN        (MEAN),
    .DRIFT_SHIFT (DRIFT_SHIFT),
    .NOISE_SHIFT (FRAC + 1)
  ) u_step (
    .env_i     (env_q[ch_q]),
    .lfsr_i    (lfsr_q[ch_q]),
    .tau_inv_i (tau_inv),
    .sigma_i   (sigma),
    .env_min_i (env_min),
    .env_max_i (env_max),
    .env_o     (step_env),
    .lfsr_o    (step_lfsr)
  );

  // Snapshot published on entry to DONE; the last channel is still in flight.
  always_comb begin
    envelope_d = '0;
    for (int k = 0; k < NCH; k++) begin
      envelope_d[k*WIDTH +: WIDTH] = env_q[k];
    end
    if (!frz_q) begin
      envelope_d[(NCH-1)*WIDTH +: WIDTH] = step_env;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      frz_q       <= 1'b0;
      envelope_q  <= MEAN_VEC;
      env_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the env/LFSR arrays are flops feeding live outputs, not a RAM,
      // so every entry is reset to a known state.
      for (int k = 0; k < NCH; k++) begin
        env_q[k]  <= WIDTH'(MEAN);
        lfsr_q[k] <= mix_seed(SEED_DEFAULT, k);
      end
    end else if (seed_load) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      frz_q       <= 1'b0;
      envelope_q  <= MEAN_VEC;
      env_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        env_q[k]  <= WIDTH'(MEAN);
        lfsr_q[k] <= mix_seed(seed_base, k);
      end
    end else begin
      env_valid_q <= 1'b0;
      if (clk_en && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (clk_en) begin
            state_q <= ST_SWEEP;
            ch_q    <= '0;
            frz_q   <= freeze;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (!frz_q) begin
            env_q[ch_q]  <= step_env;
            lfsr_q[ch_q] <= step_lfsr;
          end
          if (ch_q == LAST_CH) begin
            state_q     <= ST_DONE;
            envelope_q  <= envelope_d;
            env_valid_q <= 1'b1;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign envelope  = envelope_q;
  assign env_valid = env_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_channel_envelope_generator.sv
// Self-checking bench: behavioural OU model feeds a scoreboard queue that is
// drained on every env_valid pulse, plus table vectors and timing sequences.
`timescale 1ns/1ps
module tb_multi_channel_envelope_generator;

  localparam int WIDTH       = 18;
  localparam int NCH         = 4;
  localparam int MEAN        = 16384;
  localparam int DRIFT_SHIFT = 8;
  localparam int EW          = NCH * WIDTH;
  localparam logic [EW-1:0] MEAN_VEC = {NCH{18'd16384}};

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clk_en;
  logic                    seed_load;
  logic        [15:0]      seed_base;
  logic signed [WIDTH-1:0] tau_inv;
  logic signed [WIDTH-1:0] sigma;
  logic signed [WIDTH-1:0] env_min;
  logic signed [WIDTH-1:0] env_max;
  logic                    freeze;
  logic [EW-1:0]           envelope;
  logic                    env_valid;
  logic                    busy;
  logic                    overrun;

  multi_channel_envelope_generator #(
    .WIDTH(WIDTH), .FRAC(14), .NCH(NCH), .MEAN(MEAN),
    .DRIFT_SHIFT(DRIFT_SHIFT), .SEED_DEFAULT(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .seed_load(seed_load),
    .seed_base(seed_base), .tau_inv(tau_inv), .sigma(sigma),
    .env_min(env_min), .env_max(env_max), .freeze(freeze),
    .envelope(envelope), .env_valid(env_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;

  int          env_m  [NCH];
  logic [15:0] lfsr_m [NCH];
  int          cur_tau, cur_sig, cur_min, cur_max;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_seed(input logic [15:0] b, input int k);
    logic [31:0] p;
    logic [15:0] s;
    p = 32'(k) * 32'h0000_9E37;
    s = b ^ p[15:0];
    return (s == 16'h0000) ? 16'hACE1 : s;
  endfunction

  function automatic void model_reseed(input logic [15:0] b);
    for (int k = 0; k < NCH; k++) begin
      lfsr_m[k] = m_seed(b, k);
      env_m[k]  = MEAN;
    end
  endfunction

  function automatic logic [EW-1:0] model_pack();
    logic [EW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = WIDTH'(env_m[k]);
    return v;
  endfunction

  function automatic void model_sweep();
    longint e, n, drift, noise, s;
    logic [15:0] l;
    if (freeze) return;
    for (int k = 0; k < NCH; k++) begin
      l = lfsr_m[k];
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      lfsr_m[k] = l;
      n     = longint'(shortint'(l));
      e     = longint'(env_m[k]);
      drift = ((longint'(MEAN) - e) * longint'(cur_tau)) >>> DRIFT_SHIFT;
      noise = (n * longint'(cur_sig)) >>> 15;
      s     = e + drift + noise;
      if (s > longint'(cur_max)) s = longint'(cur_max);
      if (s < longint'(cur_min)) s = longint'(cur_min);
      env_m[k] = int'(s);
    end
  endfunction

  task automatic set_params(input int t, input int s, input int mn, input int mx);
    cur_tau = t; cur_sig = s; cur_min = mn; cur_max = mx;
    tau_inv = WIDTH'(t); sigma = WIDTH'(s); env_min = WIDTH'(mn); env_max = WIDTH'(mx);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns NCH+2 cycles later, the minimum spacing.
  task automatic do_tick();
    clk_en = 1'b1;
    model_sweep();
    exp_q.push_back(model_pack());
    step();
    clk_en = 1'b0;
    repeat (NCH + 1) step();
    check_int("tick_drained", exp_q.size(), 0);
  endtask

  task automatic do_seed(input logic [15:0] b, input logic with_tick);
    seed_load = 1'b1;
    seed_base = b;
    clk_en    = with_tick;
    exp_q.delete();
    model_reseed(b);
    step();
    seed_load = 1'b0;
    clk_en    = 1'b0;
    check_int("seed_not_busy", int'(busy), 0);
    check("seed_env_mean", envelope, MEAN_VEC);
  endtask

  // Scoreboard: every env_valid pulse must match the oldest pending prediction.
  always @(posedge clk) begin
    #1;
    if (env_valid === 1'b1) begin
      n_valid++;
      check_int("valid_has_expect", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("envelope_sb", envelope, exp_q.pop_front());
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int tau;
    int sig;
    int mn;
    int mx;
    int ticks;
    int exp_all;
  } vec_t;

  vec_t          tbl [8];
  logic [EW-1:0] snap;
  int            nv;
  longint        sum_c [NCH];
  int            lo_c  [NCH];
  int            hi_c  [NCH];
  int            fin   [NCH];
  int            v;
  int            in_bounds;
  longint        mean_c;

  initial begin
    tbl[0] = '{1,    4096,    8192,   24576, 3, -1};
    tbl[1] = '{64,   2000,  -131072, 131071, 2, -1};
    tbl[2] = '{-3,   8000,   -20000,  60000, 2, -1};
    tbl[3] = '{255, -4096,        0,  40000, 2, -1};
    tbl[4] = '{0,       0,    12000,  12000, 1, 12000};
    tbl[5] = '{0,       0,    13000,  12000, 1, 13000};
    tbl[6] = '{20,  16000,        0, 100000, 2, -1};
    tbl[7] = '{0,   30000,    16384,  16384, 1, 16384};

    rst = 1'b1; clk_en = 1'b0; seed_load = 1'b0; freeze = 1'b0; seed_base = 16'h0;
    set_params(0, 0, -131072, 131071);
    model_reseed(16'hACE1);
    #12;
    check("reset_env", envelope, MEAN_VEC);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_overrun", int'(overrun), 0);
    check_int("reset_valid", int'(env_valid), 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    check("idle_env", envelope, MEAN_VEC);
    check_int("idle_no_valid", n_valid, 0);

    // Exact pulse timing of a single tick with zero drift and noise.
    clk_en = 1'b1;
    model_sweep();
    exp_q.push_back(model_pack());
    for (int i = 1; i <= NCH + 2; i++) begin
      step();
      if (i == 1) clk_en = 1'b0;
      check_int($sformatf("valid_at_t+%0d", i), int'(env_valid), int'(i == NCH + 1));
      check_int($sformatf("busy_at_t+%0d", i), int'(busy), int'(i <= NCH + 1));
    end
    check("zero_gain_env", envelope, MEAN_VEC);

    // Asynchronous reset in the middle of a sweep.
    set_params(1, 4096, 8192, 24576);
    nv = n_valid;
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    check_int("async_rst_busy", int'(busy), 0);
    check("async_rst_env", envelope, MEAN_VEC);
    exp_q.delete();
    model_reseed(16'hACE1);
    step();
    rst = 1'b0;
    repeat (NCH + 2) step();
    check_int("async_rst_no_valid", n_valid, nv);

    for (int i = 0; i < 8; i++) begin
      set_params(tbl[i].tau, tbl[i].sig, tbl[i].mn, tbl[i].mx);
      repeat (tbl[i].ticks) do_tick();
      if (tbl[i].exp_all >= 0)
        check($sformatf("vec%0d_all", i), envelope, {NCH{WIDTH'(tbl[i].exp_all)}});
    end

    // Freeze holds state but still pulses; trajectory resumes afterwards.
    set_params(1, 4096, 8192, 24576);
    do_tick();
    snap = envelope;
    nv = n_valid;
    freeze = 1'b1;
    repeat (5) do_tick();
    check("freeze_hold", envelope, snap);
    check_int("freeze_pulses", n_valid - nv, 5);
    freeze = 1'b0;
    repeat (4) do_tick();

    // Tick at t+2 is dropped and flags overrun.
    nv = n_valid;
    clk_en = 1'b1;
    model_sweep();
    exp_q.push_back(model_pack());
    step(); clk_en = 1'b0;
    step(); clk_en = 1'b1;
    step(); clk_en = 1'b0;
    check_int("overrun_set", int'(overrun), 1);
    repeat (NCH + 1) step();
    check_int("overrun_one_pulse", n_valid - nv, 1);
    check_int("overrun_sticky", int'(overrun), 1);

    // seed_load at t+3 aborts the sweep and clears overrun.
    nv = n_valid;
    clk_en = 1'b1;
    step(); clk_en = 1'b0;
    step(); clk_en = 1'b1;
    step(); clk_en = 1'b0;
    do_seed(16'hAAAA, 1'b0);
    check_int("abort_overrun_clr", int'(overrun), 0);
    repeat (NCH + 2) step();
    check_int("abort_no_valid", n_valid, nv);

    // Reproducibility and seed sensitivity; seed_load beats a coincident tick.
    set_params(1, 4096, 8192, 24576);
    do_seed(16'hAAAA, 1'b1);
    repeat (1000) do_tick();
    snap = envelope;
    do_seed(16'hAAAA, 1'b0);
    repeat (1000) do_tick();
    check("seed_repeatable", envelope, snap);
    do_seed(16'h5555, 1'b0);
    repeat (1000) do_tick();
    check_int("seed_differs", int'(envelope != snap), 1);

    // Long statistical run.
    in_bounds = 1;
    for (int k = 0; k < NCH; k++) begin
      sum_c[k] = 0; lo_c[k] = 1 << 20; hi_c[k] = -(1 << 20);
    end
    for (int t = 0; t < 10000; t++) begin
      do_tick();
      for (int k = 0; k < NCH; k++) begin
        v = int'($signed(envelope[k*WIDTH +: WIDTH]));
        if (v < 8192 || v > 24576) in_bounds = 0;
        sum_c[k] += longint'(v);
        if (v < lo_c[k]) lo_c[k] = v;
        if (v > hi_c[k]) hi_c[k] = v;
        fin[k] = v;
      end
    end
    check_int("stat_in_bounds", in_bounds, 1);
    for (int k = 0; k < NCH; k++) begin
      mean_c = sum_c[k] / 10000;
      check_int($sformatf("stat_mean_ch%0d", k), int'(mean_c >= 13107 && mean_c <= 19661), 1);
      check_int($sformatf("stat_range_ch%0d", k), int'(hi_c[k] - lo_c[k] > 1000), 1);
      for (int j = k + 1; j < NCH; j++)
        check_int($sformatf("stat_distinct_%0d_%0d", k, j), int'(fin[k] != fin[j]), 1);
    end

    check_int("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
